// File: rtl/rr_sched_pkg.sv
// Shared types and constants for the round-robin request scheduler.
// The state encoding is fixed so that the unused code 2'd3 can be recovered explicitly.
package rr_sched_pkg;

  localparam int N_REQ   = 16;
  localparam int IDX_W   = 4;
  localparam int TO_W    = 4;
  localparam int TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: rotate so last_idx-1 sits at the MSB,
// MSB-first priority encode, then un-rotate back to a requester index.
module rr_pick #(
  parameter int N_REQ = rr_sched_pkg::N_REQ,
  parameter int IDX_W = rr_sched_pkg::IDX_W
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_idx,
  output logic [IDX_W-1:0] pick_idx,
  output logic             pick_vld
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   enc;
  logic [IDX_W:0]     sum;

  // rot[j] = req[(j + last_idx) mod N_REQ]; rot[0] is the previous winner.
  assign dbl = {req, req} >> last_idx;
  assign rot = dbl[N_REQ-1:0];

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    enc      = '0;
    pick_vld = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (rot[j]) begin
        enc      = IDX_W'(j);
        pick_vld = 1'b1;
      end
    end
  end

  assign sum      = {1'b0, enc} + {1'b0, last_idx};
  assign pick_idx = (sum >= (IDX_W+1)'(N_REQ)) ? IDX_W'(sum - (IDX_W+1)'(N_REQ))
                                                : IDX_W'(sum);

endmodule

// File: rtl/rr_req_scheduler.sv
// Round-robin scheduler granting one shared resource to one of N_REQ requesters,
// with owner release, hold timeout and a one-cycle dead gap between grants.
module rr_req_scheduler #(
  parameter int N_REQ   = rr_sched_pkg::N_REQ,
  parameter int IDX_W   = rr_sched_pkg::IDX_W,
  parameter int TIMEOUT = rr_sched_pkg::TIMEOUT,
  parameter int TO_W    = rr_sched_pkg::TO_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [N_REQ-1:0] req,
  input  logic             release_i,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             timeout_err
);

  import rr_sched_pkg::*;

  state_t           state;
  logic [IDX_W-1:0] last_idx;
  logic [TO_W-1:0]  hold_cnt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_vld;
  logic             owner_done;
  logic             at_limit;

  rr_pick #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W)
  ) u_pick (
    .req      (req),
    .last_idx (last_idx),
    .pick_idx (pick_idx),
    .pick_vld (pick_vld)
  );

  // A normal release (explicit or owner's request dropping) takes priority over timeout.
  assign owner_done = release_i | ~req[gnt_idx];
  assign at_limit   = (hold_cnt == TO_W'(TIMEOUT));

  // NOTE: all state uses non-blocking assignments; reset is asynchronous so outputs drop mid-grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_idx    <= '0;
      hold_cnt    <= '0;
      gnt         <= '0;
      gnt_idx     <= '0;
      gnt_vld     <= 1'b0;
      timeout_err <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          timeout_err <= 1'b0;
          if (pick_vld) begin
            state    <= OWN;
            gnt      <= N_REQ'(1) << pick_idx;
            gnt_idx  <= pick_idx;
            gnt_vld  <= 1'b1;
            hold_cnt <= TO_W'(1);
          end
        end
        OWN: begin
          if (owner_done || at_limit) begin
            state       <= GAP;
            last_idx    <= gnt_idx;
            gnt         <= '0;
            gnt_idx     <= '0;
            gnt_vld     <= 1'b0;
            hold_cnt    <= '0;
            timeout_err <= ~owner_done;
          end else begin
            hold_cnt <= hold_cnt + TO_W'(1);
          end
        end
        GAP: begin
          state       <= IDLE;
          timeout_err <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          hold_cnt    <= '0;
          gnt         <= '0;
          gnt_idx     <= '0;
          gnt_vld     <= 1'b0;
          timeout_err <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_req_scheduler.sv
// Self-checking bench for rr_req_scheduler: directed vectors, corner sequences,
// and randomized traffic compared against an index-arithmetic reference model.
module tb_rr_req_scheduler;

  localparam int N  = 16;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic [15:0] req = '0;
  logic        rel = 1'b0;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_vld;
  logic        timeout_err;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: owner = -1 means nobody holds the resource.
  int m_owner = -1;
  bit m_gap   = 1'b0;
  int m_held  = 0;
  int m_last  = 0;
  bit m_terr  = 1'b0;

  typedef struct {
    logic        ena;
    logic [15:0] req;
    logic        rel;
    logic [3:0]  idx;
    logic        vld;
    logic        terr;
  } vec_t;

  vec_t tbl[7];

  rr_req_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .req         (req),
    .release_i   (rel),
    .gnt         (gnt),
    .gnt_idx     (gnt_idx),
    .gnt_vld     (gnt_vld),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scan downward from last-1, wrapping, ending at last itself.
  function automatic int model_pick(input logic [15:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last - k + N) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_gap   = 1'b0;
    m_held  = 0;
    m_last  = 0;
    m_terr  = 1'b0;
  endtask

  task automatic model_step();
    int p;
    if (!rst_n || !ena) return;
    if (m_owner >= 0) begin
      if (rel || !req[m_owner]) begin
        m_last = m_owner; m_owner = -1; m_gap = 1'b1; m_terr = 1'b0;
      end else if (m_held == TO) begin
        m_last = m_owner; m_owner = -1; m_gap = 1'b1; m_terr = 1'b1;
      end else begin
        m_held++;
      end
    end else if (m_gap) begin
      m_gap  = 1'b0;
      m_terr = 1'b0;
    end else begin
      p = model_pick(req, m_last);
      if (p >= 0) begin
        m_owner = p;
        m_held  = 1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ena   = 1'b1;
    req   = '0;
    rel   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic compare_model(input string tag);
    logic [15:0] eg;
    eg = (m_owner >= 0) ? (16'h1 << m_owner) : 16'h0;
    check({tag, "_gnt"}, 32'(gnt), 32'(eg));
    check({tag, "_idx"}, 32'(gnt_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    check({tag, "_vld"}, 32'(gnt_vld), 32'(m_owner >= 0));
    check({tag, "_terr"}, 32'(timeout_err), 32'(m_terr));
  endtask

  initial begin
    // Reset state while rst_n is held low.
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_idx", 32'(gnt_idx), 32'd0);
    check("rst_vld", 32'(gnt_vld), 32'd0);
    check("rst_terr", 32'(timeout_err), 32'd0);

    // Two requesters at the extremes, release each grant after one cycle.
    tbl[0] = '{1'b1, 16'h8001, 1'b0, 4'd15, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 16'h8001, 1'b1, 4'd0,  1'b0, 1'b0};
    tbl[2] = '{1'b1, 16'h8001, 1'b0, 4'd0,  1'b0, 1'b0};
    tbl[3] = '{1'b1, 16'h8001, 1'b0, 4'd0,  1'b1, 1'b0};
    tbl[4] = '{1'b1, 16'h8001, 1'b1, 4'd0,  1'b0, 1'b0};
    tbl[5] = '{1'b1, 16'h8001, 1'b0, 4'd0,  1'b0, 1'b0};
    tbl[6] = '{1'b1, 16'h8001, 1'b0, 4'd15, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      logic [15:0] eg;
      ena = tbl[i].ena; req = tbl[i].req; rel = tbl[i].rel;
      cycle();
      eg = tbl[i].vld ? (16'h1 << tbl[i].idx) : 16'h0;
      check($sformatf("t1_v%0d_gnt", i), 32'(gnt), 32'(eg));
      check($sformatf("t1_v%0d_idx", i), 32'(gnt_idx), 32'(tbl[i].idx));
      check($sformatf("t1_v%0d_vld", i), 32'(gnt_vld), 32'(tbl[i].vld));
      check($sformatf("t1_v%0d_terr", i), 32'(timeout_err), 32'(tbl[i].terr));
    end

    // All requesting: indices rotate 15 down to 0, then wrap to 15.
    do_reset();
    req = 16'hFFFF;
    for (int g = 0; g < 17; g++) begin
      int e;
      e = (g == 16) ? 15 : 15 - g;
      rel = 1'b0;
      cycle();
      check($sformatf("t2_g%0d_idx", g), 32'(gnt_idx), 32'(e));
      check($sformatf("t2_g%0d_vld", g), 32'(gnt_vld), 32'd1);
      rel = 1'b1;
      cycle();
      check($sformatf("t2_g%0d_gap", g), 32'(gnt_vld), 32'd0);
      rel = 1'b0;
      cycle();
      check($sformatf("t2_g%0d_idle", g), 32'(gnt_vld), 32'd0);
    end

    // Single requester never releasing: held TIMEOUT cycles, then revoked.
    do_reset();
    req = 16'h0010;
    cycle();
    check("t3_idx", 32'(gnt_idx), 32'd4);
    begin
      int n = 1;
      int guard = 0;
      while (guard < 40) begin
        cycle();
        guard++;
        if (!gnt_vld) break;
        n++;
      end
      check("t3_bound", 32'(guard < 40), 32'd1);
      check("t3_hold_cycles", 32'(n), 32'(TO));
    end
    check("t3_terr_gap", 32'(timeout_err), 32'd1);
    cycle();
    check("t3_terr_idle", 32'(timeout_err), 32'd0);
    check("t3_idle_vld", 32'(gnt_vld), 32'd0);
    cycle();
    check("t3_regrant_vld", 32'(gnt_vld), 32'd1);
    check("t3_regrant_idx", 32'(gnt_idx), 32'd4);

    // Release coincides with timeout: no error, next grant skips idx7.
    do_reset();
    req = 16'h0081;
    cycle();
    check("t4_idx", 32'(gnt_idx), 32'd7);
    repeat (TO - 1) cycle();
    check("t4_still_own", 32'(gnt_vld), 32'd1);
    rel = 1'b1;
    cycle();
    check("t4_gap_vld", 32'(gnt_vld), 32'd0);
    check("t4_gap_terr", 32'(timeout_err), 32'd0);
    rel = 1'b0;
    cycle();
    cycle();
    check("t4_next_idx", 32'(gnt_idx), 32'd0);
    check("t4_next_vld", 32'(gnt_vld), 32'd1);

    // Asynchronous reset in the middle of a grant.
    do_reset();
    req = 16'h0008;
    cycle();
    check("t5_idx", 32'(gnt_idx), 32'd3);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t5_async_gnt", 32'(gnt), 32'd0);
    check("t5_async_vld", 32'(gnt_vld), 32'd0);
    check("t5_async_idx", 32'(gnt_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 16'h0009;
    cycle();
    check("t5_after_idx", 32'(gnt_idx), 32'd3);
    check("t5_after_vld", 32'(gnt_vld), 32'd1);

    // ena=0 freezes the grant even with release asserted.
    do_reset();
    req = 16'h0040;
    cycle();
    ena = 1'b0; rel = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check($sformatf("t6_frz%0d_gnt", i), 32'(gnt), 32'h40);
      check($sformatf("t6_frz%0d_vld", i), 32'(gnt_vld), 32'd1);
    end
    ena = 1'b1;
    cycle();
    check("t6_gap_vld", 32'(gnt_vld), 32'd0);
    check("t6_gap_terr", 32'(timeout_err), 32'd0);

    // ena=0 also freezes the hold counter: timeout lands 5 edges late.
    do_reset();
    req = 16'h0040;
    cycle();
    repeat (9) cycle();
    ena = 1'b0;
    repeat (5) cycle();
    ena = 1'b1;
    repeat (5) cycle();
    check("t6b_still_own", 32'(gnt_vld), 32'd1);
    cycle();
    check("t6b_revoked", 32'(gnt_vld), 32'd0);
    check("t6b_terr", 32'(timeout_err), 32'd1);

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0)
        req = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom & $urandom & $urandom);
      rel = ($urandom_range(0, 15) == 0);
      ena = ($urandom_range(0, 9) != 0);
      cycle();
      compare_model($sformatf("rnd%0d", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
